// File: rtl/vcdemux_buf_pkg.sv
// Shared widths and types for the VC demux receive buffer.
// The width/count macros can be overridden on the command line; they default to 8-bit flits and 4 VCs of depth 4.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef VCH_WIDTH_NUM
`define VCH_WIDTH_NUM 2
`endif
`ifndef VC_NUM
`define VC_NUM 4
`endif
`ifndef VC_FIFO_DEPTH
`define VC_FIFO_DEPTH 4
`endif

package vcdemux_buf_pkg;

    localparam int DATA_W        = `DATA_WIDTH;
    localparam int VCH_W         = `VCH_WIDTH_NUM;
    localparam int VC_NUM        = `VC_NUM;
    localparam int VC_FIFO_DEPTH = `VC_FIFO_DEPTH;

    typedef logic [DATA_W-1:0] flit_t;
    typedef logic [VCH_W-1:0]  vch_t;

    // Tags outside 0..VC_NUM-1 decode to no VC at all.
    function automatic logic [VC_NUM-1:0] vc_onehot(input logic valid, input vch_t vch);
        logic [VC_NUM-1:0] oh;
        oh = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            oh[i] = valid && (vch == vch_t'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/vcdemux_buf_if.sv
// Link-side and router-side signal bundle of the VC demux buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface vcdemux_buf_if;
    import vcdemux_buf_pkg::*;

    logic                     ivalid;
    vch_t                     ivch;
    flit_t                    idata;
    logic [VC_NUM-1:0]        ovalid;
    logic [VC_NUM*DATA_W-1:0] odata;
    logic [VC_NUM*VCH_W-1:0]  ovch;
    logic [VC_NUM-1:0]        ready;
    logic [VC_NUM-1:0]        ocredit;
    logic                     ovf_err;

    modport master (
        output ivalid, ivch, idata, ready,
        input  ovalid, odata, ovch, ocredit, ovf_err
    );

    modport slave (
        input  ivalid, ivch, idata, ready,
        output ovalid, odata, ovch, ocredit, ovf_err
    );

endinterface

// File: rtl/vcdemux_buf_vc_fifo.sv
// Single-write / single-read synchronous FIFO holding the flits of one VC.
// Caller only pushes when not full (or popping) and only pops when not empty.
module vc_fifo
    import vcdemux_buf_pkg::*;
#(
    parameter int DEPTH = VC_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  flit_t                      wdata,
    output logic                       full,
    output logic                       empty,
    output flit_t                      head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    flit_t            mem_q [DEPTH];
    flit_t            mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q==0 already masks stale entries and head is forced to 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vcdemux_buf.sv
// Receive-side VC demux: steers link flits into per-VC FIFOs, presents heads, returns credits.
// Define VCDEMUX_OVF_CHECK_EN to build the sticky ovf_err detector; otherwise ovf_err is tied 0.
module vcdemux_buf
    import vcdemux_buf_pkg::*;
#(
    parameter int DEPTH = VC_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    vcdemux_buf_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [VC_NUM-1:0] push_req, push_ok, pop;
    logic [VC_NUM-1:0] full, empty;
    logic [VC_NUM-1:0] credit_q, credit_d;
    flit_t             head  [VC_NUM];
    logic [CNT_W-1:0]  count [VC_NUM];

    // A full VC still takes a flit when its head leaves in the same cycle.
    always_comb begin
        push_req = vc_onehot(bus.ivalid, bus.ivch);
        pop      = bus.ready & ~empty;
        push_ok  = push_req & (~full | pop);
        credit_d = pop;
    end

    for (genvar n = 0; n < VC_NUM; n++) begin : g_vc
        vc_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push_ok[n]),
            .pop   (pop[n]),
            .wdata (bus.idata),
            .full  (full[n]),
            .empty (empty[n]),
            .head  (head[n]),
            .count (count[n])
        );

        assign bus.ovalid[n]                  = ~empty[n];
        assign bus.odata[n*DATA_W +: DATA_W]  = head[n];
        assign bus.ovch[n*VCH_W +: VCH_W]     = vch_t'(n);

        a_count_range: assert property (@(posedge clk) disable iff (!reset)
            count[n] <= CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign bus.ocredit = credit_q;

`ifdef VCDEMUX_OVF_CHECK_EN
    logic ovf_q, ovf_d, bad_vch;

    if (VCH_W > 2) begin : g_vch_chk
        assign bad_vch = bus.ivalid && (32'(bus.ivch) >= VC_NUM);
    end else begin : g_vch_ok
        assign bad_vch = 1'b0;
    end

    always_comb begin
        ovf_d = ovf_q | (|(push_req & ~push_ok)) | bad_vch;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf_err = ovf_q;
`else
    assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_vcdemux_buf.sv
// Scoreboard bench for vcdemux_buf: a queue-based reference model predicts every cycle's outputs,
// a separate monitor compares them and the in-order delivery of each popped flit.
module tb_vcdemux_buf;
    import vcdemux_buf_pkg::*;

    localparam int DEPTH = VC_FIFO_DEPTH;
`ifdef VCDEMUX_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vcdemux_buf_if bus ();
    vcdemux_buf #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [VC_NUM-1:0]        ovalid;
        logic [VC_NUM*DATA_W-1:0] odata;
        logic [VC_NUM-1:0]        ocredit;
        logic                     ovf;
    } exp_t;

    exp_t              exp_q [$];
    flit_t             model_q [VC_NUM][$];
    flit_t             pop_q   [VC_NUM][$];
    logic [VC_NUM-1:0] model_credit;
    logic              model_ovf;
    logic              mon_en = 1'b0;
    int                credit_seen [VC_NUM];
    int                assert_cnt = 0;
    int                fail_cnt   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares one predicted cycle per falling edge, plus each flit the DUT hands out.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    assert_cnt++;
                    fail_cnt++;
                    $display("FAIL scoreboard: no prediction queued (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ovalid",  bus.ovalid,  e.ovalid);
                    check("odata",   bus.odata,   e.odata);
                    check("ocredit", bus.ocredit, e.ocredit);
                    check("ovf_err", bus.ovf_err, e.ovf);
                end
                for (int n = 0; n < VC_NUM; n++) begin
                    credit_seen[n] += int'(bus.ocredit[n]);
                    if (bus.ovalid[n] && bus.ready[n]) begin
                        if (pop_q[n].size() == 0) begin
                            assert_cnt++;
                            fail_cnt++;
                            $display("FAIL pop_vc%0d: unexpected pop of %0h", n, bus.odata[n*DATA_W +: DATA_W]);
                        end else begin
                            check($sformatf("pop_vc%0d", n), bus.odata[n*DATA_W +: DATA_W], pop_q[n].pop_front());
                        end
                    end
                end
            end
        end
    end

    // One clock cycle: queue the expected outputs for the current state, drive inputs, advance the model.
    task automatic cycle(input logic v, input vch_t ch, input flit_t d, input logic [VC_NUM-1:0] rdy);
        exp_t              e;
        logic [VC_NUM-1:0] pops;
        int                size_before [VC_NUM];
        int                vc;
        e.ovalid  = '0;
        e.odata   = '0;
        for (int n = 0; n < VC_NUM; n++) begin
            size_before[n] = model_q[n].size();
            if (size_before[n] > 0) begin
                e.ovalid[n]                  = 1'b1;
                e.odata[n*DATA_W +: DATA_W]  = model_q[n][0];
            end
        end
        e.ocredit = model_credit;
        e.ovf     = model_ovf;
        exp_q.push_back(e);
        mon_en = 1'b1;

        bus.ivalid = v;
        bus.ivch   = ch;
        bus.idata  = d;
        bus.ready  = rdy;

        pops = '0;
        for (int n = 0; n < VC_NUM; n++) begin
            if (rdy[n] && size_before[n] > 0) begin
                pops[n] = 1'b1;
                pop_q[n].push_back(model_q[n].pop_front());
            end
        end
        if (v) begin
            vc = int'(ch);
            if (vc >= VC_NUM) model_ovf = model_ovf | OVF_EN;
            else if (size_before[vc] < DEPTH || pops[vc]) model_q[vc].push_back(d);
            else model_ovf = model_ovf | OVF_EN;
        end
        model_credit = pops;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [VC_NUM-1:0] rdy);
        repeat (n) cycle(1'b0, '0, '0, rdy);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, then releases after an edge.
    task automatic apply_reset();
        mon_en     = 1'b0;
        reset      = 1'b0;
        bus.ivalid = 1'b0;
        bus.ivch   = '0;
        bus.idata  = '0;
        bus.ready  = '0;
        #1;
        check("rst_ovalid",  bus.ovalid,  '0);
        check("rst_odata",   bus.odata,   '0);
        check("rst_ocredit", bus.ocredit, '0);
        check("rst_ovf_err", bus.ovf_err, '0);
        exp_q.delete();
        for (int n = 0; n < VC_NUM; n++) begin
            model_q[n].delete();
            pop_q[n].delete();
            credit_seen[n] = 0;
        end
        model_credit = '0;
        model_ovf    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VC_NUM*VCH_W-1:0] exp_ovch;
        logic [VC_NUM-1:0]       rdy;
        int                      pending;

        reset = 1'b1;
        #2;
        apply_reset();

        // Reset then idle, and the constant VC tags.
        idle(3, '0);
        for (int n = 0; n < VC_NUM; n++) exp_ovch[n*VCH_W +: VCH_W] = vch_t'(n);
        check("ovch", bus.ovch, exp_ovch);

        // Single flit through VC2, one credit back.
        cycle(1'b1, vch_t'(2), flit_t'('hA1), '0);
        cycle(1'b0, '0, '0, 4'b0100);
        idle(3, '0);

        // Reset while flits are buffered and a credit is pending: nothing survives it.
        cycle(1'b1, vch_t'(0), flit_t'('h55), '0);
        cycle(1'b1, vch_t'(3), flit_t'('h66), '0);
        cycle(1'b1, vch_t'(3), flit_t'('h67), 4'b1001);
        apply_reset();
        idle(3, '0);

        // Fill VC0, then a push with no pop is dropped.
        for (int i = 0; i < 4; i++) cycle(1'b1, vch_t'(0), flit_t'('h10 + i), '0);
        cycle(1'b1, vch_t'(0), flit_t'('h14), '0);
        idle(2, '0);
        idle(6, 4'b0001);

        // Full VC with a same-cycle pop accepts the new flit.
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, vch_t'(0), flit_t'('h10 + i), '0);
        cycle(1'b1, vch_t'(0), flit_t'('h14), 4'b0001);
        idle(6, 4'b0001);

        // Interleaved traffic on all VCs with every ready high.
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, vch_t'(i % VC_NUM), flit_t'('h20 + i), 4'hF);
        idle(4, 4'hF);

        // Ten flits streamed through VC1 wrap the pointers.
        apply_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, vch_t'(1), flit_t'('h30 + i), 4'b0010);
        idle(3, 4'b0010);
        check("vc1_credits", credit_seen[1], 10);

        // Random traffic, with a reset dropped into the middle.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset();
            rdy = VC_NUM'($urandom);
            cycle($urandom_range(0, 9) < 7, vch_t'($urandom_range(0, VC_NUM-1)), flit_t'($urandom), rdy);
        end
        idle(DEPTH + 2, '1);
        pending = 0;
        for (int n = 0; n < VC_NUM; n++) pending += pop_q[n].size() + model_q[n].size();
        check("drained", pending, 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
